// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory bus between icache (loads) and dcache (loads/stores).
// Optional icache aging priority is enabled with the MEM_ARB_AGING_EN macro.
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned AGE_LIMIT       = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               icache_req_valid,
    input  logic [`XLEN-1:0]   icache_req_addr,
    output logic               icache_req_ready,
    input  logic               dcache_req_valid,
    input  logic [1:0]         dcache_req_command,
    input  logic [`XLEN-1:0]   dcache_req_addr,
    input  logic [63:0]        dcache_req_data,
    output logic               dcache_req_ready,
    output logic [1:0]         proc2mem_command,
    output logic [63:0]        proc2mem_addr,
    output logic [63:0]        proc2mem_data,
    input  logic [3:0]         mem2proc_response,
    input  logic [63:0]        mem2proc_data,
    input  logic [3:0]         mem2proc_tag,
    output logic               icache_resp_valid,
    output logic [63:0]        icache_resp_data,
    output logic               dcache_resp_valid,
    output logic [63:0]        dcache_resp_data,
    output logic [3:0]         loads_in_flight,
    output logic               proto_error
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } owner_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    // Index 0 is never written (tag 0 means "no tag"), so it stays invalid.
    logic [15:0] entry_valid;
    logic [15:0] entry_owner;
    logic [15:0] next_valid;
    logic [15:0] next_owner;
    logic [3:0]  next_count;

    logic load_ok, dcache_store, dcache_elig, icache_elig, icache_first;
    logic grant_d, grant_i, granted, acc_load, ret_hit, err_now;

`ifdef MEM_ARB_AGING_EN
    localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);
    logic [2:0] age;
`endif

    always_comb begin
        load_ok      = loads_in_flight < MAX_CNT;
        dcache_store = dcache_req_command == BUS_STORE;
        dcache_elig  = dcache_req_valid && (dcache_store || load_ok);
        icache_elig  = icache_req_valid && load_ok;
`ifdef MEM_ARB_AGING_EN
        icache_first = icache_elig && ({1'b0, age} >= AGE_LIM);
`else
        icache_first = 1'b0;
`endif
        grant_d = dcache_elig && !icache_first;
        grant_i = icache_elig && !grant_d;
        granted = (mem2proc_response != 4'd0) && !reset;
        acc_load = granted && (grant_i || (grant_d && !dcache_store));
        ret_hit = (mem2proc_tag != 4'd0) && entry_valid[mem2proc_tag];
    end

    always_comb begin
        proc2mem_command  = BUS_NONE;
        proc2mem_addr     = '0;
        proc2mem_data     = '0;
        icache_req_ready  = 1'b0;
        dcache_req_ready  = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_data  = '0;
        dcache_resp_valid = 1'b0;
        dcache_resp_data  = '0;
        if (!reset) begin
            if (grant_d) begin
                proc2mem_command = dcache_store ? BUS_STORE : BUS_LOAD;
                proc2mem_addr    = 64'(dcache_req_addr);
                proc2mem_data    = dcache_store ? dcache_req_data : '0;
                dcache_req_ready = granted;
            end else if (grant_i) begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = 64'(icache_req_addr);
                icache_req_ready = granted;
            end
            if (ret_hit) begin
                if (entry_owner[mem2proc_tag] == OWN_DCACHE) begin
                    dcache_resp_valid = 1'b1;
                    dcache_resp_data  = mem2proc_data;
                end else begin
                    icache_resp_valid = 1'b1;
                    icache_resp_data  = mem2proc_data;
                end
            end
        end
    end

    // Return clears before grant sets, so a same-cycle re-grant of the returning tag is legal.
    always_comb begin
        next_valid = entry_valid;
        next_owner = entry_owner;
        if (ret_hit)
            next_valid[mem2proc_tag] = 1'b0;
        if (acc_load) begin
            next_valid[mem2proc_response] = 1'b1;
            next_owner[mem2proc_response] = grant_d ? OWN_DCACHE : OWN_ICACHE;
        end
        err_now = ((mem2proc_tag != 4'd0) && !entry_valid[mem2proc_tag]) ||
                  (acc_load && entry_valid[mem2proc_response] &&
                   !(ret_hit && (mem2proc_tag == mem2proc_response)));
        next_count = '0;
        for (int unsigned i = 0; i < 16; i++)
            next_count = next_count + 4'(next_valid[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_valid     <= '0;
            entry_owner     <= '0;
            loads_in_flight <= '0;
            proto_error     <= 1'b0;
        end else begin
            entry_valid     <= next_valid;
            entry_owner     <= next_owner;
            loads_in_flight <= next_count;
            proto_error     <= proto_error | err_now;
        end
    end

`ifdef MEM_ARB_AGING_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            age <= '0;
        else if (grant_i && granted)
            age <= '0;
        else if (icache_elig && (age != 3'd7))
            age <= age + 3'd1;
    end
`endif

endmodule
